// File: rtl/adder_digit_serial.sv
// Digit-serial adder/subtractor. Each operation takes WIDTH/DIGIT cycles, least
// significant digit first, with valid/ready handshakes on the input and output sides.
module adder_digit_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // WIDTH must be a multiple of DIGIT.
   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   logic [KW-1:0]    k;

   logic [DIGIT-1:0] a_d;
   logic [DIGIT-1:0] b_d;
   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             d_cmsb;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic             accept;

   assign a_d = a_q[DIGIT-1:0];
   assign b_d = b_q[DIGIT-1:0];
   assign {d_cout, d_sum} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, c_q};
   // Carry into the digit's top bit, recovered from that bit's sum and operands.
   assign d_cmsb = d_sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];

   generate
      if (NDIG > 1) begin : g_shift
         assign sum_next = {d_sum, sum[WIDTH-1:DIGIT]};
         assign a_next   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
         assign b_next   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      end else begin : g_flat
         assign sum_next = d_sum;
         assign a_next   = a_q;
         assign b_next   = b_q;
      end
   endgenerate

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high. in_ready is high in IDLE, and follows out_ready in DONE so a new operation
   // can be captured on the same edge that retires the result.
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= 1'b0;
         k         <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         a_q       <= a;
         b_q       <= sub ? ~b : b;
         c_q       <= sub ^ cin;
         k         <= '0;
         out_valid <= 1'b0;
         state     <= RUN;
      end else begin
         case (state)
            RUN: begin
               sum <= sum_next;
               a_q <= a_next;
               b_q <= b_next;
               c_q <= d_cout;
               k   <= k + 1'b1;
               if (k == KLAST) begin
                  cout      <= d_cout;
                  ovf       <= d_cmsb ^ d_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_digit_serial.sv
// Bench for adder_digit_serial: four instances (3/1, 8/2, 8/8, 32/4) share one
// stimulus bus; sel picks which one is driven and observed.
module tb_adder_digit_serial;

   localparam int NDUT = 4;
   localparam int W_TAB [NDUT] = '{3, 8, 8, 32};
   localparam int D_TAB [NDUT] = '{1, 2, 8, 4};
   localparam int LIM = 400;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   int          sel;
   logic        rnd_ready;

   logic        iv   [NDUT];
   logic        orv  [NDUT];
   logic        ir   [NDUT];
   logic        ov   [NDUT];
   logic        co   [NDUT];
   logic        of   [NDUT];
   logic [2:0]  sum0;
   logic [7:0]  sum1;
   logic [7:0]  sum2;
   logic [31:0] sum3;

   logic        obs_ir;
   logic        obs_ov;
   logic        obs_co;
   logic        obs_of;
   logic [31:0] obs_sum;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NDUT; i++) begin
         iv[i]  = in_valid && (sel == i);
         orv[i] = out_ready && (sel == i);
      end
   end

   always_comb begin
      obs_ir  = ir[sel];
      obs_ov  = ov[sel];
      obs_co  = co[sel];
      obs_of  = of[sel];
      obs_sum = '0;
      case (sel)
         0:       obs_sum = {29'd0, sum0};
         1:       obs_sum = {24'd0, sum1};
         2:       obs_sum = {24'd0, sum2};
         default: obs_sum = sum3;
      endcase
   end

   adder_digit_serial #(.WIDTH(3), .DIGIT(1)) u_w3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub),
      .out_valid(ov[0]), .out_ready(orv[0]), .sum(sum0), .cout(co[0]), .ovf(of[0]));

   adder_digit_serial #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
      .out_valid(ov[1]), .out_ready(orv[1]), .sum(sum1), .cout(co[1]), .ovf(of[1]));

   adder_digit_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
      .out_valid(ov[2]), .out_ready(orv[2]), .sum(sum2), .cout(co[2]), .ovf(of[2]));

   adder_digit_serial #(.WIDTH(32), .DIGIT(4)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov[3]), .out_ready(orv[3]), .sum(sum3), .cout(co[3]), .ovf(of[3]));

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: no DUT response within %0d cycles (sel=%0d)", name, LIM, sel);
   endtask

   // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
   function automatic logic [33:0] model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                         input logic tc, input logic ts);
      logic [63:0] mask, ua, ub, raw;
      longint      sa, sb, exact, lim;
      logic        c_o, o_f;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, ta} & mask;
      ub   = {32'd0, tb} & mask;
      lim  = longint'(64'd1 << (w - 1));
      sa   = longint'(ua);
      sb   = longint'(ub);
      if (sa >= lim) sa = sa - (lim << 1);
      if (sb >= lim) sb = sb - (lim << 1);
      if (ts) begin
         raw   = ua + (ub ^ mask) + 64'(!tc);
         exact = sa - sb - longint'(tc);
      end else begin
         raw   = ua + ub + 64'(tc);
         exact = sa + sb + longint'(tc);
      end
      c_o = raw[w];
      o_f = (exact >= lim) || (exact < -lim);
      return {c_o, o_f, 32'(raw & mask)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int          acc_q[$];
   int          cyc = 0;
   int          n_acc = 0;
   logic        prev_ov = 1'b0;
   logic        prev_or = 1'b0;
   logic [33:0] prev_res = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov = 1'b0;
         prev_or = 1'b0;
      end else begin
         cyc++;
         if (obs_ov && !prev_ov) begin
            if (acc_q.size() == 0) check("spurious_valid", 64'(obs_ov), 64'd0);
            else check("sb_latency", 64'(cyc - acc_q.pop_front()), 64'(W_TAB[sel] / D_TAB[sel] + 1));
         end
         if (prev_ov && !prev_or) begin
            check("hold_valid", 64'(obs_ov), 64'd1);
            check("hold_result", 64'({obs_co, obs_of, obs_sum}), 64'(prev_res));
         end
         if (obs_ov && !out_ready) check("busy_in_ready", 64'(obs_ir), 64'd0);
         if (obs_ov && out_ready) begin
            if (exp_q.size() == 0) check("spurious_result", 64'(obs_ov), 64'd0);
            else check("sb_result", 64'({obs_co, obs_of, obs_sum}), 64'(exp_q.pop_front()));
         end
         if (in_valid && obs_ir) begin
            exp_q.push_back(model(W_TAB[sel], a, b, cin, sub));
            acc_q.push_back(cyc);
            n_acc++;
         end
         prev_ov  = obs_ov;
         prev_or  = out_ready;
         prev_res = {obs_co, obs_of, obs_sum};
      end
   end

   // ---------------- driver tasks (called from negedge time points) ----------------
   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
      int t = 0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      while (!obs_ir && t < LIM) begin
         @(negedge clk);
         t++;
      end
      if (t >= LIM) timeout_fail("accept_wait");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_valid(output int cycles);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!obs_ov && t < LIM);
      if (!obs_ov) timeout_fail("valid_wait");
      cycles = t - 1;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("retire_valid", 64'(obs_ov), 64'd0);
   endtask

   task automatic run_op(input int s, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic eco, input logic eof, input string name);
      int lat;
      sel = s;
      #1;
      send(ta, tb, tc, ts);
      wait_valid(lat);
      check({name, "_latency"}, 64'(lat), 64'(W_TAB[s] / D_TAB[s]));
      check({name, "_sum"}, 64'(obs_sum), 64'(es));
      check({name, "_cout"}, 64'(obs_co), 64'(eco));
      check({name, "_ovf"}, 64'(obs_of), 64'(eof));
      retire();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          s;
      logic [31:0] va;
      logic [31:0] vb;
      logic        vc;
      logic        vs;
      logic [31:0] esum;
      logic        ecout;
      logic        eovf;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int lat;
      logic [33:0] r;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0; sel = 0;

      vecs[0] = '{1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{1, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b1};
      vecs[2] = '{1, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
      vecs[3] = '{2, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1};
      vecs[4] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
      vecs[5] = '{3, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[6] = '{3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[7] = '{3, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[8] = '{0, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[9] = '{2, 32'h0000_0080, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_007E, 1'b1, 1'b1};

      // reset state of every instance
      #12;
      for (int s = 0; s < NDUT; s++) begin
         sel = s;
         #1;
         check("rst_out_valid", 64'(obs_ov), 64'd0);
         check("rst_in_ready", 64'(obs_ir), 64'd1);
         check("rst_sum", 64'(obs_sum), 64'd0);
         check("rst_cout_ovf", 64'({obs_co, obs_of}), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // exhaustive 3-bit add
      for (int i = 0; i < 128; i++) begin
         logic [6:0] v;
         int         t;
         v = 7'(i);
         t = int'(v[6:4]) + int'(v[3:1]) + int'(v[0]);
         r = model(3, {29'd0, v[6:4]}, {29'd0, v[3:1]}, v[0], 1'b0);
         run_op(0, {29'd0, v[6:4]}, {29'd0, v[3:1]}, v[0], 1'b0,
                32'(t & 7), (t >> 3) != 0, r[32], "w3_add");
      end

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].s, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs,
                vecs[i].esum, vecs[i].ecout, vecs[i].eovf, $sformatf("vec%0d", i));

      // backpressure in DONE, then back-to-back accept on the retiring edge
      sel = 1;
      #1;
      send(32'h12, 32'h34, 1'b0, 1'b0);
      wait_valid(lat);
      a = 32'h50; b = 32'h0A; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(obs_ov), 64'd1);
         check("bp_sum", 64'(obs_sum), 64'h46);
         check("bp_in_ready", 64'(obs_ir), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 64'(obs_ir), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = $urandom; b = $urandom;
      check("b2b_retired", 64'(obs_ov), 64'd0);
      wait_valid(lat);
      check("b2b_latency", 64'(lat), 64'd4);
      check("b2b_sum", 64'(obs_sum), 64'h5A);
      retire();

      // reset while the second digit is being processed
      @(negedge clk);
      send(32'h33, 32'h44, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(obs_ov), 64'd0);
      check("abort_sum", 64'(obs_sum), 64'd0);
      check("abort_cout", 64'(obs_co), 64'd0);
      check("abort_in_ready", 64'(obs_ir), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(1, 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0, "post_abort");

      // randomized traffic with valid and ready gaps
      for (int ph = 0; ph < 2; ph++) begin
         sel = (ph == 0) ? 3 : 2;
         rnd_ready = 1'b1;
         @(negedge clk);
         fork
            begin
               for (int i = 0; i < 1500; i++) begin
                  int target;
                  int t;
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  target = n_acc + 1;
                  a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
                  in_valid = 1'b1;
                  t = 0;
                  do begin
                     @(negedge clk);
                     t++;
                  end while (n_acc < target && t < LIM);
                  in_valid = 1'b0;
                  if (n_acc < target) timeout_fail("rnd_accept");
               end
               begin
                  int t = 0;
                  while (exp_q.size() != 0 && t < LIM) begin
                     @(negedge clk);
                     t++;
                  end
                  if (exp_q.size() != 0) timeout_fail("rnd_drain");
               end
               rnd_ready = 1'b0;
            end
            begin
               while (rnd_ready) begin
                  @(negedge clk);
                  out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
               end
               out_ready = 1'b0;
            end
         join
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
